// File: rtl/iter_func_pkg.sv
// iter_func_pkg: FSM states, regime codes and per-regime iteration counts for iter_func_unit.
package iter_func_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  localparam logic [1:0] REG_NONE   = 2'd0;
  localparam logic [1:0] REG_POPCNT = 2'd1;
  localparam logic [1:0] REG_ISQRT  = 2'd2;
  localparam logic [1:0] REG_REV    = 2'd3;
  function automatic int iter_count(input logic [1:0] r, input int w);
    return (r == REG_ISQRT) ? w / 2 : w;
  endfunction
endpackage

// File: rtl/iter_func_step.sv
// iter_func_step: one combinational iteration of popcount, restoring isqrt or bit reversal.
module iter_func_step
  import iter_func_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       regime,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] nx,
  output logic [WIDTH-1:0] nacc,
  output logic [WIDTH-1:0] nrem
);
  logic [WIDTH+1:0] sh, trial;
  logic fit;
  always_comb begin
    sh    = {rem, x[WIDTH-1 -: 2]};
    trial = {acc, 2'b01};
    fit   = sh >= trial;
    nx    = (regime == REG_ISQRT) ? x << 2 : x >> 1;
    // the isqrt remainder never exceeds WIDTH/2+1 bits, so truncation is lossless
    nrem  = WIDTH'(fit ? sh - trial : sh);
    nacc  = (regime == REG_POPCNT) ? acc + WIDTH'(x[0]) :
            (regime == REG_ISQRT)  ? {acc[WIDTH-2:0], fit} :
                                     {acc[WIDTH-2:0], x[0]};
  end
endmodule

// File: rtl/iter_func_unit.sv
// iter_func_unit: multi-cycle popcount / isqrt / bit-reverse unit with held result and done pulse.
// Define ITER_FUNC_RESTART_EN to allow start in DONE to re-enter RUN directly.
module iter_func_unit
  import iter_func_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int STEP_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  x,
  input  logic [1:0]        on,
  input  logic              start,
  output logic [WIDTH-1:0]  y,
  output logic [STEP_W-1:0] s,
  output logic              b,
  output logic              active,
  output logic [1:0]        regime,
  output logic              done
);
  if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
    $error("iter_func_unit: WIDTH must be even and >= 2");
  end
  state_t state;
  logic [WIDTH-1:0] xr, acc, rem, nx, nacc, nrem;
  logic [STEP_W-1:0] n, s1;
  logic [1:0] eff;
  logic gate, go;
  iter_func_step #(.WIDTH(WIDTH)) u_step (
    .regime(regime), .x(xr), .acc(acc), .rem(rem),
    .nx(nx), .nacc(nacc), .nrem(nrem)
  );
  assign active = regime != REG_NONE;
  always_comb begin
    eff = (on != REG_NONE) ? on : regime;
    n   = STEP_W'(iter_count(regime, WIDTH));
    s1  = s + STEP_W'(1);
`ifdef ITER_FUNC_RESTART_EN
    go  = start && eff != REG_NONE && (state == DONE || (gate && (state == IDLE || state == ARMED)));
`else
    go  = start && eff != REG_NONE && gate && (state == IDLE || state == ARMED);
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      y      <= '0;
      s      <= '0;
      b      <= 1'b0;
      regime <= REG_NONE;
      done   <= 1'b0;
      gate   <= 1'b1;
      xr     <= '0;
      acc    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      if (state != RUN && on != REG_NONE) regime <= on;
      // the DONE cycle closes the gate unless start is already low there
      if (state != RUN) gate <= (gate && state != DONE) || !start;
      if (state == IDLE && on != REG_NONE) state <= ARMED;
      if (state == DONE) state <= ARMED;
      if (state == RUN) begin
        xr  <= nx;
        acc <= nacc;
        rem <= nrem;
        s   <= s1;
        if (s1 == n) begin
          state <= DONE;
          y     <= nacc;
          done  <= 1'b1;
          b     <= 1'b0;
        end
      end
      if (go) begin
        state  <= RUN;
        b      <= 1'b1;
        s      <= '0;
        xr     <= x;
        acc    <= '0;
        rem    <= '0;
        regime <= eff;
      end
    end
  end
endmodule

// File: tb/tb_iter_func_unit.sv
// tb_iter_func_unit: directed checks of iter_func_unit (WIDTH=16 with ITER_FUNC_RESTART_EN, else 8).
module tb_iter_func_unit;
  import iter_func_pkg::*;
`ifdef ITER_FUNC_RESTART_EN
  localparam int W = 16;
`else
  localparam int W = 8;
`endif
  localparam int SW = $clog2(W + 1);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, b, active, done;
  logic [W-1:0] x = '0, y;
  logic [1:0] on = 2'd0, regime;
  logic [SW-1:0] s;
  int checks = 0, errors = 0;

  iter_func_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .x(x), .on(on), .start(start),
    .y(y), .s(s), .b(b), .active(active), .regime(regime), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({y, s, b, active, regime, done} !== '0) begin
      errors++;
      $display("FAIL reset: y=%0d s=%0d b=%b active=%b regime=%0d done=%b, required all 0", y, s, b, active, regime, done);
    end
    rst = 1'b0;
    tick();
  endtask

`ifndef ITER_FUNC_RESTART_EN
  task automatic test_isqrt_same_edge();
    x = W'(98); on = REG_ISQRT; start = 1'b1;
    tick();
    on = REG_NONE;
    checks++;
    if ({b, s, regime, active, done} !== {1'b1, SW'(0), REG_ISQRT, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL isqrt_entry: b=%b s=%0d regime=%0d active=%b done=%b, required 1 0 2 1 0", b, s, regime, active, done);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if ({b, done, s} !== {1'b1, 1'b0, SW'(k)}) begin
        errors++;
        $display("FAIL isqrt_step%0d: b=%b done=%b s=%0d, required 1 0 %0d", k, b, done, s, k);
      end
    end
    tick();
    checks++;
    if ({b, done, s, y} !== {1'b0, 1'b1, SW'(4), W'(9)}) begin
      errors++;
      $display("FAIL isqrt_done: b=%b done=%b s=%0d y=%0d, required 0 1 4 9", b, done, s, y);
    end
  endtask

  task automatic test_start_gate();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({b, done, s, y} !== {1'b0, 1'b0, SW'(4), W'(9)}) begin
        errors++;
        $display("FAIL gate_hold%0d: b=%b done=%b s=%0d y=%0d, required 0 0 4 9", k, b, done, s, y);
      end
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    checks++;
    if ({b, s} !== {1'b1, SW'(0)}) begin
      errors++;
      $display("FAIL gate_rerun: b=%b s=%0d, required 1 0", b, s);
    end
    repeat (4) tick();
    checks++;
    if ({done, y, b} !== {1'b1, W'(9), 1'b0}) begin
      errors++;
      $display("FAIL gate_result: done=%b y=%0d b=%b, required 1 9 0", done, y, b);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_regime_hold();
    on = REG_REV;
    tick();
    on = REG_NONE;
    tick();
    checks++;
    if (regime !== REG_REV) begin
      errors++;
      $display("FAIL rev_regime: regime=%0d, required 3", regime);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++;
    if ({b, y, regime} !== {1'b1, W'(9), REG_REV}) begin
      errors++;
      $display("FAIL rev_running: b=%b y=%0d regime=%0d, required 1 9 3", b, y, regime);
    end
    tick();
    checks++;
    if ({done, y, s} !== {1'b1, W'(70), SW'(8)}) begin
      errors++;
      $display("FAIL rev_done: done=%b y=%0d s=%0d, required 1 70 8", done, y, s);
    end
    on = REG_POPCNT;
    tick();
    on = REG_NONE;
    checks++;
    if ({regime, s, done} !== {REG_POPCNT, SW'(8), 1'b0}) begin
      errors++;
      $display("FAIL pop_regime: regime=%0d s=%0d done=%b, required 1 8 0", regime, s, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    checks++;
    if ({done, y, s} !== {1'b1, W'(3), SW'(8)}) begin
      errors++;
      $display("FAIL pop_done: done=%b y=%0d s=%0d, required 1 3 8", done, y, s);
    end
  endtask

  task automatic test_run_ignores_inputs();
    tick();
    x = W'(98); on = REG_ISQRT; start = 1'b1;
    tick();
    x = '1; on = REG_REV; start = 1'b0;
    tick();
    checks++;
    if ({b, regime} !== {1'b1, REG_ISQRT}) begin
      errors++;
      $display("FAIL run_ign1: b=%b regime=%0d, required 1 2", b, regime);
    end
    tick();
    on = REG_NONE;
    checks++;
    if (regime !== REG_ISQRT) begin
      errors++;
      $display("FAIL run_ign2: regime=%0d, required 2", regime);
    end
    tick();
    tick();
    checks++;
    if ({done, y, regime} !== {1'b1, W'(9), REG_ISQRT}) begin
      errors++;
      $display("FAIL run_ign_done: done=%b y=%0d regime=%0d, required 1 9 2", done, y, regime);
    end
  endtask

  task automatic test_reset_mid_run();
    tick();
    x = W'(98); on = REG_ISQRT; start = 1'b1;
    tick();
    on = REG_NONE; start = 1'b0;
    repeat (3) tick();
    checks++;
    if ({b, s} !== {1'b1, SW'(3)}) begin
      errors++;
      $display("FAIL midrun_pre: b=%b s=%0d, required 1 3", b, s);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({y, s, b, active, regime, done} !== '0) begin
      errors++;
      $display("FAIL midrun_rst: y=%0d s=%0d b=%b active=%b regime=%0d done=%b, required all 0", y, s, b, active, regime, done);
    end
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if ({b, regime, active, s} !== {1'b0, REG_NONE, 1'b0, SW'(0)}) begin
      errors++;
      $display("FAIL midrun_ignore: b=%b regime=%0d active=%b s=%0d, required 0 0 0 0", b, regime, active, s);
    end
    start = 1'b0;
  endtask
`else
  task automatic test_back_to_back();
    x = '1; on = REG_ISQRT; start = 1'b1;
    tick();
    on = REG_NONE;
    checks++;
    if ({b, s, regime} !== {1'b1, SW'(0), REG_ISQRT}) begin
      errors++;
      $display("FAIL b2b_entry: b=%b s=%0d regime=%0d, required 1 0 2", b, s, regime);
    end
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 8; k++) begin
        tick();
        checks++;
        if (k < 8) begin
          if ({b, done, s, y} !== {1'b1, 1'b0, SW'(k), (r == 0) ? W'(0) : W'(255)}) begin
            errors++;
            $display("FAIL b2b_run%0d_step%0d: b=%b done=%b s=%0d y=%0d", r, k, b, done, s, y);
          end
        end else if ({b, done, s, y} !== {1'b0, 1'b1, SW'(8), W'(255)}) begin
          errors++;
          $display("FAIL b2b_done%0d: b=%b done=%b s=%0d y=%0d, required 0 1 8 255", r, b, done, s, y);
        end
      end
      tick();
      checks++;
      if ({b, done, s} !== {1'b1, 1'b0, SW'(0)}) begin
        errors++;
        $display("FAIL b2b_restart%0d: b=%b done=%b s=%0d, required 1 0 0", r, b, done, s);
      end
    end
    start = 1'b0;
    repeat (9) tick();
    checks++;
    if ({b, y} !== {1'b0, W'(255)}) begin
      errors++;
      $display("FAIL b2b_stop: b=%b y=%0d, required 0 255", b, y);
    end
  endtask

  task automatic test_idle_start_ignored();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; on = REG_NONE;
    tick();
    tick();
    checks++;
    if ({b, regime, y} !== {1'b0, REG_NONE, W'(0)}) begin
      errors++;
      $display("FAIL idle_ignore: b=%b regime=%0d y=%0d, required 0 0 0", b, regime, y);
    end
    start = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifndef ITER_FUNC_RESTART_EN
    test_isqrt_same_edge();
    test_start_gate();
    test_regime_hold();
    test_run_ignores_inputs();
    test_reset_mid_run();
`else
    test_back_to_back();
    test_idle_start_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_func_unit.md
# iter_func_unit

Parametrised multi-regime iterative function unit: a successor to the 8-bit single-operand task unit, generalised to WIDTH-bit operands with a done pulse and optional back-to-back restart. A regime (popcount, integer square root, bit reversal) is selected with `on`. `start` launches a multi-cycle computation on `x`. The unit reports busy, step count and the active regime, and holds the result on `y` until the next completion.

## Interface
- WIDTH, 8, operand/result width; must be even and ≥ 2 (elaboration error otherwise)
- STEP_W, $clog2(WIDTH+1), width of step counter `s` (derived, not overridden)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- x  in  WIDTH  operand, sampled only on the RUN-entry edge
- on  in  2  regime request: 0 none, 1 popcount, 2 isqrt, 3 bit-reverse
- start  in  1  level request to run
- y  out  WIDTH  last result, held
- s  out  STEP_W  iterations completed in current/last run
- b  out  1  busy (state RUN)
- active  out  1  regime ≠ 0
- regime  out  2  current regime
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset: IDLE; y=0, s=0, b=0, active=0, regime=0, done=0.
- Effective regime: reg_eff = (on≠0) ? on : regime.
- IDLE/ARMED, at the clock edge:
  - If on≠0, regime←on and the state becomes at least ARMED. on=0 never clears regime.
  - If start=1, reg_eff≠0 and the start gate is open: latch x, regime←reg_eff, s←0, go to RUN. Starting in the same edge as a regime load is legal.
  - If start=1 with reg_eff=0: ignored; remain in IDLE.
- RUN: on, x and start are ignored. Each edge performs one iteration, then s←s+1. After iteration N, go to DONE, load y with the result, done=1.
  - N = WIDTH for popcount: count one bit per cycle, LSB first.
  - N = WIDTH/2 for isqrt: restoring bit-pair method, result = floor(sqrt(x)), upper bits zero.
  - N = WIDTH for reverse: one bit per cycle, y[i] = x[WIDTH-1-i].
- DONE (one cycle): done=1, s=N, b=0. Next edge goes to ARMED, or to RUN when the restart feature applies.
- Start gate: after DONE, start must be sampled low at least once before a new run. A start held high does not retrigger.
- The `on` value in the DONE cycle updates regime exactly as in ARMED.
- `s` stays at its last value in ARMED until the next run clears it.

## Timing
- Edge E0 samples start: state=RUN, s=0, b=1.
- Edge E0+k (k<N): s=k.
- Edge E0+N: DONE, y valid, done=1, s=N.
- Start-to-result latency is N cycles. y does not change between DONE pulses.
- Async rst mid-RUN: everything returns to reset values immediately. The partial result is discarded and y=0.
- on and start in the same edge: regime load and run start both take effect, and the run uses `on`.

## Configuration
- ITER_FUNC_RESTART_EN defined:
  - In DONE with start=1, the next edge re-enters RUN directly, latching new x and reg_eff, with no ARMED cycle and no low-start requirement.
  - Back-to-back throughput is one result per N+1 cycles.
- ITER_FUNC_RESTART_EN undefined: start gate rule above applies.

## Structure
- Package iter_func_pkg:
  - state enum (IDLE, ARMED, RUN, DONE)
  - regime constants REG_NONE=0, REG_POPCNT=1, REG_ISQRT=2, REG_REV=3
  - function iter_count(regime, WIDTH)
- Sub-module iter_func_step: combinational single-iteration datapath (popcount bit-add, isqrt restoring step, reverse shift) selected by regime. The top holds the FSM, counters and registers.

## Test plan
- WIDTH=8, x=98, on=2 with start=1 in the same edge: b high 4 cycles, s 0→4, y=9, done one pulse, regime=2, active=1.
- Hold start=1 after DONE (macro off): no second run. Drop start for 1 cycle, raise again: new run, y=9.
- on=3 pulse 1 cycle then on=0, start: regime stays 3, 8 iterations, y=70. Then on=1 pulse, start: y=3 after 8 cycles.
- Change x and on during RUN: result unaffected, regime unchanged until DONE.
- Assert rst at iteration 3 of an isqrt run: immediate y=0, s=0, b=0, regime=0, state IDLE. start with on=0 afterwards is ignored.
- ITER_FUNC_RESTART_EN, WIDTH=16, x=65535, regime 2, start held: y=255 every 9 cycles with no idle gap. start with on=0 from IDLE is ignored.
